// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared types and width helpers for the LED sequencer.
//
// Contents:
//   state_e        - sequencer FSM states (IDLE, RUN)
//   NUM_CH_MIN/MAX - legal channel-count range
//   PHASE_MIN      - shortest legal phase length in clocks
//   PWM_WIDTH_MAX  - widest legal PWM counter
//   idx_width()    - width of the channel index / phase_idx
//   cnt_width()    - width of the per-phase cycle counter
//
// Optional feature macro used by the files importing this package:
//   LED_SEQ_PWM_EN - enables duty-cycle dimming of the lit channel.
// -----------------------------------------------------------------------------
package led_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int NUM_CH_MIN    = 2;
  localparam int NUM_CH_MAX    = 16;
  localparam int PHASE_MIN     = 2;
  localparam int PWM_WIDTH_MAX = 8;

  // Width of an index that must address n channels. The legal range starts
  // at 2 channels, but the floor of 1 keeps the helper safe for any input.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter running 0 .. p-1.
  function automatic int cnt_width(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/led_seq_pwm.sv
// -----------------------------------------------------------------------------
// led_seq_pwm
// Free-running PWM counter and duty comparator used to dim the lit LED.
// Only instantiated when LED_SEQ_PWM_EN is defined.
//
// The counter wraps modulo 2^PWM_WIDTH and starts from 0 after reset.
// pwm_on is 1 while the counter is below duty, so:
//   duty = 0              -> never on
//   duty = 2^PWM_WIDTH-1  -> off exactly one cycle per period
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset, clears the counter
//   duty   in   PWM_WIDTH brightness setting
//   pwm_on out  combinational compare of the current counter against duty
// -----------------------------------------------------------------------------
module led_seq_pwm #(
  parameter int PWM_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PWM_WIDTH-1:0] duty,
  output logic                 pwm_on
);

  logic [PWM_WIDTH-1:0] pwm_cnt_q;
  logic [PWM_WIDTH-1:0] pwm_cnt_d;

  // Natural binary overflow provides the modulo 2^PWM_WIDTH wrap.
  assign pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_on = (pwm_cnt_q < duty);

endmodule

// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
// Lights NUM_CH LEDs one at a time, PHASE_CYCLES clocks each, after a rising
// edge on button. Runs once (pulsing done at the end) or repeats forever when
// loop_mode is high at the wrap point. abort returns to IDLE at once.
//
// Parameters:
//   NUM_CH       number of LED channels (2..16)
//   PHASE_CYCLES clocks each channel stays lit (2..65536)
//   PWM_WIDTH    duty / PWM counter width (1..8)
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high reset
//   button     in   start request, rising-edge sensitive
//   loop_mode  in   1 = repeat, 0 = one-shot; sampled at each wrap
//   abort      in   level, forces IDLE; beats every other event but reset
//   duty       in   PWM_WIDTH brightness (only with LED_SEQ_PWM_EN)
//   led        out  NUM_CH registered one-hot or zero drive
//   busy       out  registered, 1 while in RUN (direct view of the FSM state)
//   phase_idx  out  registered index of the lit channel, 0 in IDLE
//   done       out  registered one-cycle pulse when a one-shot run completes
//
// Configuration macro:
//   LED_SEQ_PWM_EN - when defined, the lit channel is gated by led_seq_pwm;
//                    otherwise duty is ignored and the lit channel is solid.
//
// Handshake / timing: there is no valid/ready traffic. button is treated as an
// edge event, every output is a register and reflects the state entered on
// the clock edge that follows the causing input cycle.
// -----------------------------------------------------------------------------
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int PHASE_CYCLES = 10,
  parameter int PWM_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      button,
  input  logic                      loop_mode,
  input  logic                      abort,
  input  logic [PWM_WIDTH-1:0]      duty,
  output logic [NUM_CH-1:0]         led,
  output logic                      busy,
  output logic [$clog2(NUM_CH)-1:0] phase_idx,
  output logic                      done
);

  localparam int IDX_W = idx_width(NUM_CH);
  localparam int CNT_W = cnt_width(PHASE_CYCLES);

  localparam logic [IDX_W-1:0] CH_LAST  = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] led_q, led_d;
  logic              done_q, done_d;
  logic              button_q;
  logic              armed_q;
  logic              start;
  logic              lit;

  // ---------------------------------------------------------------------------
  // Start detection
  // armed_q blocks a button that is already held when reset releases: it is
  // loaded with ~button during reset and only sets once button is seen low,
  // so such a press needs a fresh rising edge. A button that is low during
  // reset leaves armed_q set, so an edge right after reset still counts.
  // ---------------------------------------------------------------------------
  assign start = button & ~button_q & armed_q;

  // ---------------------------------------------------------------------------
  // Brightness gate for the lit channel
  // ---------------------------------------------------------------------------
`ifdef LED_SEQ_PWM_EN
  led_seq_pwm #(
    .PWM_WIDTH (PWM_WIDTH)
  ) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .duty   (duty),
    .pwm_on (lit)
  );
`else
  logic unused_duty;
  assign unused_duty = ^duty;
  assign lit         = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    led_d   = '0;

    if (abort) begin
      // Abort wins over start, phase advance and wrap; it never pulses done.
      state_d = IDLE;
      ch_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            ch_d    = '0;
            cnt_d   = '0;
          end
        end

        RUN: begin
          // Presses during RUN are ignored: no branch here looks at start.
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (ch_q == CH_LAST) begin
              ch_d = '0;
              if (!loop_mode) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              ch_d = ch_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = IDLE;
          ch_d    = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Computed from the next state so led lines up with busy/phase_idx.
    if ((state_d == RUN) && lit) begin
      led_d = NUM_CH'(1) << ch_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      led_q    <= '0;
      done_q   <= 1'b0;
      button_q <= 1'b0;
      armed_q  <= ~button;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      done_q   <= done_d;
      button_q <= button;
      armed_q  <= armed_q | ~button;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ch_q is forced to 0 on every entry to IDLE, so it doubles as phase_idx.
  // ---------------------------------------------------------------------------
  assign led       = led_q;
  assign busy      = (state_q == RUN);
  assign phase_idx = ch_q;
  assign done      = done_q;

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of LED channels, range 2..16.
REQ-002 SHALL have parameter PHASE_CYCLES, default 10: clocks each channel stays lit, range 2..2^16.
REQ-003 SHALL have parameter PWM_WIDTH, default 4: duty/PWM counter width, range 1..8.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port button  in  1  start request, rising-edge sensitive, synchronous to clk.
REQ-007 SHALL have port loop_mode  in  1  1 = repeat sequence, 0 = one-shot; sampled at each wrap decision.
REQ-008 SHALL have port abort  in  1  level; forces return to IDLE.
REQ-009 SHALL have port duty  in  PWM_WIDTH  brightness of the lit channel (used only under REQ-027).
REQ-010 SHALL have port led  out  NUM_CH  registered one-hot (or zero) channel drive.
REQ-011 SHALL have port busy  out  1  registered; 1 while in RUN.
REQ-012 SHALL have port phase_idx  out  $clog2(NUM_CH)  registered index of the lit channel, 0 in IDLE.
REQ-013 SHALL have port done  out  1  registered one-cycle pulse on one-shot completion.

Function
REQ-014 SHALL implement FSM states IDLE and RUN, plus a channel index ch and phase counter cnt (width $clog2(PHASE_CYCLES)).
REQ-015 SHALL detect start as button==1 while the previous-cycle registered button==0; a held button SHALL NOT retrigger.
REQ-016 IDLE -> RUN on start with abort==0; led[0], busy, ch=0, cnt=0 SHALL be visible on the clock edge following the start cycle (1-cycle latency).
REQ-017 In RUN, cnt SHALL increment each clock; at cnt==PHASE_CYCLES-1 it SHALL clear and ch SHALL advance, so each channel is lit exactly PHASE_CYCLES cycles.
REQ-018 At the terminal count of ch==NUM_CH-1: loop_mode==1 -> ch=0, stay RUN with no gap cycle; loop_mode==0 -> IDLE, led=0, busy=0, done=1 for exactly one cycle on that same edge.
REQ-019 abort==1 SHALL take priority over all events: next edge goes to IDLE, led=0, busy=0, cnt=0, ch=0, done=0.
REQ-020 start during RUN SHALL be ignored (no restart); start coincident with abort in IDLE SHALL be ignored.
REQ-021 led SHALL be all-zero in IDLE; in RUN exactly bit ch may be set, never more than one bit.
REQ-022 done SHALL never assert in loop mode or on abort.

Reset
REQ-023 On reset high at a rising clk edge: state=IDLE, ch=0, cnt=0, led=0, busy=0, phase_idx=0, done=0, registered button=0, PWM counter=0.
REQ-024 reset mid-RUN SHALL behave as abort with priority over abort and start; a button already high when reset releases SHALL NOT start (needs a fresh rising edge).

Configuration
REQ-025 Macro LED_SEQ_PWM_EN selects dimming.
REQ-026 Without LED_SEQ_PWM_EN: duty SHALL be ignored; the lit channel is driven constantly 1.
REQ-027 With LED_SEQ_PWM_EN: a free-running PWM_WIDTH counter wraps modulo 2^PWM_WIDTH; lit bit = 1 when counter < duty; duty=0 -> always dark, duty=2^PWM_WIDTH-1 -> dark one cycle per period; busy/phase_idx/done timing unchanged.

Structure
REQ-028 Package led_seq_pkg SHALL hold the state_e enum (IDLE, RUN) and PWM/phase width helper constants.
REQ-029 The PWM counter and comparator SHALL be a sub-module led_seq_pwm, instantiated only under LED_SEQ_PWM_EN.

Verification
REQ-030 Defaults, one-shot: button 0->1 at cycle 5 -> led=001 cycles 6-15, 010 cycles 16-25, 100 cycles 26-35; cycle 36 led=000, busy=0, done=1 for one cycle.
REQ-031 loop_mode=1, button held high 100 cycles -> led sequence 001/010/100 repeats with period 30, no zero cycles, no retrigger, done never 1.
REQ-032 abort=1 at cycle 20 of RUN -> next edge led=000, busy=0, phase_idx=0, done=0; new button edge restarts at led=001.
REQ-033 reset pulse mid-RUN with button held -> all outputs zero after the edge, no start until button falls and rises again.
REQ-034 NUM_CH=5, PHASE_CYCLES=2, one-shot -> each of 5 bits lit 2 cycles, done 10 cycles after first led edge.
REQ-035 LED_SEQ_PWM_EN, PWM_WIDTH=2, duty=1 -> lit channel high 1 of every 4 cycles; duty=0 -> led stays 000 while busy=1.
